// File: rtl/svc_rv_hazard_seq.sv
// Hazard sequencer for the RV pipeline: load-use bubbles, redirect flushes and
// multi-cycle M-extension holds. Optional stats counters under SVC_RV_HAZ_STATS_EN.
module svc_rv_hazard_seq #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             is_m_ex,
    input  logic [2:0]       funct3_ex,
    input  logic             redirect_ex,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             m_busy,
    output logic             m_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Nine bits so a 256-cycle divide is representable before the N-2 load.
    localparam logic [8:0] MUL_N = 9'(MUL_CYCLES);
    localparam logic [8:0] DIV_N = 9'(DIV_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] n_sel;
    logic [8:0] n_m2;
    logic       lu;

    always_comb begin
        n_sel = funct3_ex[2] ? DIV_N : MUL_N;
        n_m2  = n_sel - 9'd2;
        lu    = mem_read_ex && (rd_ex != 5'd0) &&
                ((rs1_used_id && (rs1_id == rd_ex)) ||
                 (rs2_used_id && (rs2_id == rd_ex)));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_pc = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;

        // Outputs are held quiet while reset is asserted so an aborted op
        // releases the pipeline immediately, not on the next edge.
        if (!rst) begin
            if (redirect_ex) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
                state_d  = ST_IDLE;
                cnt_d    = 8'd0;
            end else if (state_q == ST_BUSY) begin
                m_busy = 1'b1;
                if (cnt_q != 8'd0) begin
                    stall_pc = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                end else begin
                    m_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end else if (is_m_ex && (n_sel >= 9'd2)) begin
                stall_pc = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                state_d  = ST_BUSY;
                cnt_d    = n_m2[7:0];
            end else begin
                if (is_m_ex) begin
                    m_done = 1'b1;
                end
                if (lu) begin
                    stall_pc = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SVC_RV_HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Free-running, wrapping event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_pc);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_svc_rv_hazard_seq.sv
// Directed bench for svc_rv_hazard_seq: vector table for single-cycle hazards,
// hand sequences for M-op timing, redirect override, reset abort and stats.
module tb_svc_rv_hazard_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used_id, rs2_used_id, mem_read_ex, is_m_ex, redirect_ex;
    logic [2:0]  funct3_ex;
    logic        stall_pc, stall_id, stall_ex, flush_id, flush_ex, m_busy, m_done;
    logic [31:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    svc_rv_hazard_seq #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(33),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .is_m_ex(is_m_ex), .funct3_ex(funct3_ex), .redirect_ex(redirect_ex),
        .stall_pc(stall_pc), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .m_busy(m_busy), .m_done(m_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // {stall_pc, stall_id, stall_ex, flush_id, flush_ex, m_busy, m_done}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1u;
        logic       rs2u;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic [6:0] exp;
    } vec_t;

    vec_t vt[10];

    function automatic logic [6:0] outs();
        return {stall_pc, stall_id, stall_ex, flush_id, flush_ex, m_busy, m_done};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_cnt(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        is_m_ex = 1'b0; funct3_ex = 3'd0; redirect_ex = 1'b0;
    endtask

    // Every task below starts just after a falling edge and ends on one.
    task automatic m_seq(input logic [2:0] f3, input int n, input string nm);
        logic s;
        is_m_ex = 1'b1;
        funct3_ex = f3;
        for (int c = 1; c <= n; c++) begin
            s = (c < n);
            #1 check($sformatf("%s_c%0d", nm, c), outs(),
                     {s, s, s, 1'b0, 1'b0, (c >= 2), (c == n)});
            @(negedge clk);
        end
        is_m_ex = 1'b0;
        funct3_ex = 3'd0;
        #1 check({nm, "_after"}, outs(), 7'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nstall;
        int done_c;
        logic [31:0] exp_st, exp_fl;

        vt[0] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 7'b1100100};
        vt[1] = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 7'b1100100};
        vt[2] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 7'b0000000};
        vt[3] = '{5'd3,  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 7'b0000000};
        vt[4] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 7'b0000000};
        vt[5] = '{5'd6,  5'd4,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 7'b0000000};
        vt[6] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 7'b0001100};
        vt[7] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 7'b0001100};
        vt[8] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 7'b1100100};
        vt[9] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b0000000};

        clr_in();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check("reset_outs", outs(), 7'b0);
        check_cnt("reset_stall_cnt", stall_cnt, 32'd0);
        check_cnt("reset_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle hazard table.
        for (int i = 0; i < 10; i++) begin
            rs1_id = vt[i].rs1; rs2_id = vt[i].rs2;
            rs1_used_id = vt[i].rs1u; rs2_used_id = vt[i].rs2u;
            rd_ex = vt[i].rd; mem_read_ex = vt[i].mr; redirect_ex = vt[i].redir;
            #1 check($sformatf("vec%0d", i), outs(), vt[i].exp);
            @(negedge clk);
        end
        clr_in();

        // Load-use for one cycle, then the load is gone.
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        #1 check("lu_cycle", outs(), 7'b1100100);
        @(negedge clk);
        mem_read_ex = 1'b0; rd_ex = 5'd0;
        #1 check("lu_next", outs(), 7'b0);
        @(negedge clk);
        clr_in();

        m_seq(3'd4, 33, "div");
        m_seq(3'd0, 2, "mul");

        // Back-to-back MULs restart from IDLE the cycle after m_done.
        is_m_ex = 1'b1; funct3_ex = 3'd0;
        for (int c = 1; c <= 4; c++) begin
            #1 check($sformatf("b2b_c%0d", c), outs(),
                     (c % 2 == 1) ? 7'b1110000 : 7'b0000011);
            @(negedge clk);
        end
        is_m_ex = 1'b0;
        #1 check("b2b_after", outs(), 7'b0);
        @(negedge clk);

        // funct3 changing while busy does not stretch a MUL.
        is_m_ex = 1'b1; funct3_ex = 3'd0;
        #1 check("f3chg_c1", outs(), 7'b1110000);
        @(negedge clk);
        funct3_ex = 3'd4;
        #1 check("f3chg_c2", outs(), 7'b0000011);
        @(negedge clk);
        is_m_ex = 1'b0; funct3_ex = 3'd0;
        #1 check("f3chg_after", outs(), 7'b0);
        @(negedge clk);

        // Redirect during BUSY wins and drops the FSM to IDLE.
        is_m_ex = 1'b1; funct3_ex = 3'd0;
        #1 check("rdbusy_c1", outs(), 7'b1110000);
        @(negedge clk);
        redirect_ex = 1'b1;
        #1 check("rdbusy_redir", outs(), 7'b0001100);
        @(negedge clk);
        redirect_ex = 1'b0;
        #1 check("rdbusy_restart", outs(), 7'b1110000);
        @(negedge clk);
        #1 check("rdbusy_done", outs(), 7'b0000011);
        @(negedge clk);
        is_m_ex = 1'b0;
        #1 check("rdbusy_after", outs(), 7'b0);
        @(negedge clk);

        // Reset in cycle 10 of a DIV, then a fresh full-length op.
        is_m_ex = 1'b1; funct3_ex = 3'd4;
        for (int c = 1; c < 10; c++) @(negedge clk);
        #1 check("rstdiv_c10", outs(), 7'b1110010);
        rst = 1'b1;
        #1 check("rstdiv_async", outs(), 7'b0);
        @(negedge clk);
        #1 check("rstdiv_held", outs(), 7'b0);
        rst = 1'b0;
        nstall = 0;
        done_c = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (stall_pc) nstall++;
            if (m_done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        check_cnt("rstdiv_stalls", 32'(nstall), 32'd32);
        check_cnt("rstdiv_done_cycle", 32'(done_c), 32'd33);
        @(negedge clk);
        is_m_ex = 1'b0; funct3_ex = 3'd0;
        #1 check("rstdiv_after", outs(), 7'b0);
        @(negedge clk);

        // Stats: one load-use, one DIV, two redirects.
        rst = 1'b1;
        #1 check_cnt("stats_clr_st", stall_cnt, 32'd0);
        check_cnt("stats_clr_fl", flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used_id = 1'b1;
        @(negedge clk);
        clr_in();
        m_seq(3'd4, 33, "stdiv");
        redirect_ex = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_ex = 1'b0;
        @(negedge clk);
`ifdef SVC_RV_HAZ_STATS_EN
        exp_st = 32'd33;
        exp_fl = 32'd2;
`else
        exp_st = 32'd0;
        exp_fl = 32'd0;
`endif
        #1 check_cnt("stats_stall_cnt", stall_cnt, exp_st);
        check_cnt("stats_flush_cnt", flush_cnt, exp_fl);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
